// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the single-port RAM arbiter.
package ram_arb_pkg;

  // Which host port owns the response in the cycle after a grant.
  typedef enum logic [1:0] {
    RSP_NONE  = 2'd0,
    RSP_INSTR = 2'd1,
    RSP_DATA  = 2'd2
  } rsp_tag_e;

  // Width of the fetch starvation counter; holds limits up to 15.
  localparam int unsigned StarveCntW = 4;

  // True when addr falls inside the power-of-two window [base, base+size).
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] size);
    return (addr & ~(size - 32'd1)) == base;
  endfunction

endpackage

// File: rtl/ram_arb_starve_ctr.sv
// Saturating counter of consecutive data grants taken while a fetch waits.
module ram_arb_starve_ctr
  import ram_arb_pkg::*;
#(
  parameter int unsigned Limit = 4
) (
  input  logic clk_sys_i,
  input  logic rst_sys_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic limit_reached_o
);

  logic [StarveCntW-1:0] cnt_q, cnt_d;

  // Clear has priority over increment; count saturates at Limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q < StarveCntW'(Limit))) begin
      cnt_d = cnt_q + StarveCntW'(1);
    end
  end

  // Counter state register.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign limit_reached_o = (cnt_q >= StarveCntW'(Limit));

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port, 1-cycle-latency RAM between fetch and data ports.
// Data has priority; a starvation guard forces a fetch grant after
// MaxDataBurst consecutive data grants while a fetch is pending.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned MemSize      = 65536,
  parameter logic [31:0] MemStart     = 32'h0000_0000,
  parameter int unsigned MaxDataBurst = 4,
  parameter int unsigned AddrWidth    = 14
) (
  input  logic                 clk_sys_i,
  input  logic                 rst_sys_ni,
  input  logic                 instr_req_i,
  input  logic [31:0]          instr_addr_i,
  output logic                 instr_gnt_o,
  output logic                 instr_rvalid_o,
  output logic [31:0]          instr_rdata_o,
  output logic                 instr_err_o,
  input  logic                 data_req_i,
  input  logic                 data_we_i,
  input  logic [3:0]           data_be_i,
  input  logic [31:0]          data_addr_i,
  input  logic [31:0]          data_wdata_i,
  output logic                 data_gnt_o,
  output logic                 data_rvalid_o,
  output logic [31:0]          data_rdata_o,
  output logic                 data_err_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [3:0]           mem_be_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  input  logic [31:0]          mem_rdata_i
);

  logic        limit_reached;
  logic        starve_inc, starve_clr;
  logic [31:0] sel_addr;
  logic        in_range;
  logic        any_gnt;

  rsp_tag_e    rsp_tag_q, rsp_tag_d;
  logic        err_q, err_d;
  logic        rd_q, rd_d;

  logic        unused_addr_lsb;

  ram_arb_starve_ctr #(
    .Limit (MaxDataBurst)
  ) u_starve_ctr (
    .clk_sys_i       (clk_sys_i),
    .rst_sys_ni      (rst_sys_ni),
    .inc_i           (starve_inc),
    .clr_i           (starve_clr),
    .limit_reached_o (limit_reached)
  );

  // Arbitration: data first unless the fetch has waited out the burst limit.
  always_comb begin
    instr_gnt_o = 1'b0;
    data_gnt_o  = 1'b0;
    if (data_req_i && !limit_reached) begin
      data_gnt_o = 1'b1;
    end else if (instr_req_i) begin
      instr_gnt_o = 1'b1;
    end else if (data_req_i) begin
      data_gnt_o = 1'b1;
    end
    starve_inc = data_gnt_o && instr_req_i;
    starve_clr = instr_gnt_o || !instr_req_i;
  end

  // RAM drive; the data port supplies every field unless a fetch is granted.
  always_comb begin
    any_gnt     = instr_gnt_o || data_gnt_o;
    sel_addr    = instr_gnt_o ? instr_addr_i : data_addr_i;
    in_range    = addr_in_range(sel_addr, MemStart, 32'(MemSize));
    mem_req_o   = any_gnt && in_range;
    mem_addr_o  = sel_addr[AddrWidth+1:2];
    mem_we_o    = instr_gnt_o ? 1'b0 : data_we_i;
    mem_be_o    = instr_gnt_o ? 4'hF : data_be_i;
    mem_wdata_o = data_wdata_i;
  end

  // Byte offset is intentionally dropped: misaligned accesses hit the word.
  assign unused_addr_lsb = ^sel_addr[1:0];

  // Next response owner, error flag and read-forward flag, latched at grant.
  always_comb begin
    rsp_tag_d = RSP_NONE;
    if (instr_gnt_o) begin
      rsp_tag_d = RSP_INSTR;
    end else if (data_gnt_o) begin
      rsp_tag_d = RSP_DATA;
    end
    err_d = any_gnt && !in_range;
    rd_d  = mem_req_o && !mem_we_o;
  end

  // Response pipeline register; reset drops any pending response.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      rsp_tag_q <= RSP_NONE;
      err_q     <= 1'b0;
      rd_q      <= 1'b0;
    end else begin
      rsp_tag_q <= rsp_tag_d;
      err_q     <= err_d;
      rd_q      <= rd_d;
    end
  end

  // Response steering: RAM data only reaches the owning port on a good read.
  always_comb begin
    instr_rvalid_o = (rsp_tag_q == RSP_INSTR);
    data_rvalid_o  = (rsp_tag_q == RSP_DATA);
    instr_err_o    = instr_rvalid_o && err_q;
    data_err_o     = data_rvalid_o && err_q;
    instr_rdata_o  = (instr_rvalid_o && rd_q) ? mem_rdata_i : '0;
    data_rdata_o   = (data_rvalid_o && rd_q) ? mem_rdata_i : '0;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a behavioural single-port RAM.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_req = 1'b0;
  logic [31:0] instr_addr = '0;
  logic        instr_gnt, instr_rvalid, instr_err;
  logic [31:0] instr_rdata;
  logic        data_req = 1'b0, data_we = 1'b0;
  logic [3:0]  data_be = '0;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic        data_gnt, data_rvalid, data_err;
  logic [31:0] data_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  typedef struct {
    bit          is_instr;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] ram [16384];

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .MemSize      (65536),
    .MemStart     (32'h0000_0000),
    .MaxDataBurst (4),
    .AddrWidth    (14)
  ) dut (
    .clk_sys_i      (clk),
    .rst_sys_ni     (rst_n),
    .instr_req_i    (instr_req),
    .instr_addr_i   (instr_addr),
    .instr_gnt_o    (instr_gnt),
    .instr_rvalid_o (instr_rvalid),
    .instr_rdata_o  (instr_rdata),
    .instr_err_o    (instr_err),
    .data_req_i     (data_req),
    .data_we_i      (data_we),
    .data_be_i      (data_be),
    .data_addr_i    (data_addr),
    .data_wdata_i   (data_wdata),
    .data_gnt_o     (data_gnt),
    .data_rvalid_o  (data_rvalid),
    .data_rdata_o   (data_rdata),
    .data_err_o     (data_err),
    .mem_req_o      (mem_req),
    .mem_we_o       (mem_we),
    .mem_be_o       (mem_be),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_rdata_i    (mem_rdata)
  );

  // Single-port RAM, read data valid the cycle after the request.
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every rvalid pops one expected response.
  always @(negedge clk) begin
    if (instr_rvalid || data_rvalid) begin
      n_checks++;
      if (instr_rvalid && data_rvalid) begin
        n_fail++;
        $display("FAIL rsp_both: instr_rvalid=1 data_rvalid=1 expected one at %0t", $time);
      end else if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: rvalid with empty scoreboard at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.is_instr != instr_rvalid) begin
          n_fail++;
          $display("FAIL rsp_port: instr_rvalid=%0b expected %0b at %0t", instr_rvalid, e.is_instr, $time);
        end else if (e.is_instr) begin
          check("instr_rdata", instr_rdata, e.rdata);
          check("instr_err", 32'(instr_err), 32'(e.err));
          check("data_rdata_idle", data_rdata, 32'h0);
        end else begin
          check("data_rdata", data_rdata, e.rdata);
          check("data_err", 32'(data_err), 32'(e.err));
          check("instr_rdata_idle", instr_rdata, 32'h0);
        end
      end
    end
  end

  // One request cycle: drive at negedge, check grants and RAM drive, queue the response.
  task automatic cyc(input logic ireq, input logic [31:0] iaddr,
                     input logic dreq, input logic dwe, input logic [3:0] dbe,
                     input logic [31:0] daddr, input logic [31:0] dwd,
                     input logic eig, input logic edg, input logic emreq,
                     input logic [13:0] emaddr, input logic ewe, input logic [3:0] ebe,
                     input logic [31:0] erd, input logic eerr, input string nm);
    exp_t e;
    @(negedge clk);
    instr_req = ireq; instr_addr = iaddr;
    data_req = dreq; data_we = dwe; data_be = dbe; data_addr = daddr; data_wdata = dwd;
    #1;
    check({nm, "_igrant"}, 32'(instr_gnt), 32'(eig));
    check({nm, "_dgrant"}, 32'(data_gnt), 32'(edg));
    check({nm, "_mreq"}, 32'(mem_req), 32'(emreq));
    if (emreq) begin
      check({nm, "_maddr"}, 32'(mem_addr), 32'(emaddr));
      check({nm, "_mwe"}, 32'(mem_we), 32'(ewe));
      check({nm, "_mbe"}, 32'(mem_be), 32'(ebe));
    end
    if (eig || edg) begin
      e.is_instr = eig; e.rdata = erd; e.err = eerr;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    instr_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16384; i++) ram[i] = '0;
    ram[14'h40] = 32'h0000_0013;

    // Reset state
    #12;
    check("rst_instr_rvalid", 32'(instr_rvalid), 32'h0);
    check("rst_data_rvalid", 32'(data_rvalid), 32'h0);
    check("rst_instr_rdata", instr_rdata, 32'h0);
    check("rst_data_rdata", data_rdata, 32'h0);
    check("rst_errs", 32'({instr_err, data_err}), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    idle();

    // Fetch, then misaligned fetch to the same word
    cyc(1, 32'h100, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 1, 14'h40, 0, 4'hF, 32'h13, 0, "fetch");
    cyc(1, 32'h103, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 1, 14'h40, 0, 4'hF, 32'h13, 0, "misalign");

    // Partial write then back-to-back read
    cyc(0, 32'h0, 1, 1, 4'b0011, 32'h80, 32'hDEADBEEF, 0, 1, 1, 14'h20, 1, 4'b0011, 32'h0, 0, "wr");
    cyc(0, 32'h0, 1, 0, 4'hF, 32'h80, 32'h0, 0, 1, 1, 14'h20, 0, 4'hF, 32'h0000BEEF, 0, "rd");

    // Contention for 12 cycles: D,D,D,D,I repeating
    for (int k = 0; k < 12; k++) begin
      if (k % 5 == 4)
        cyc(1, 32'h100, 1, 0, 4'hF, 32'h80, 32'h0, 1, 0, 1, 14'h40, 0, 4'hF, 32'h13, 0, "starve");
      else
        cyc(1, 32'h100, 1, 0, 4'hF, 32'h80, 32'h0, 0, 1, 1, 14'h20, 0, 4'hF, 32'h0000BEEF, 0, "starve");
    end

    // Withdrawn requests: no grant, no RAM access, no response
    cyc(0, 32'h100, 0, 0, 4'hF, 32'h80, 32'h0, 0, 0, 0, 14'h0, 0, 4'h0, 32'h0, 0, "withdraw");

    // Out-of-range data read and fetch
    cyc(0, 32'h0, 1, 0, 4'hF, 32'h8000_0000, 32'h0, 0, 1, 0, 14'h0, 0, 4'h0, 32'h0, 1, "oor_data");
    cyc(1, 32'h0001_0000, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 14'h0, 0, 4'h0, 32'h0, 1, "oor_fetch");
    idle();

    // Reset while a data read is pending: no response follows
    @(negedge clk);
    data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h80;
    #1;
    check("rstmid_dgrant", 32'(data_gnt), 32'h1);
    rst_n = 1'b0;
    idle();
    idle();
    @(negedge clk); rst_n = 1'b1;
    idle();
    idle();
    cyc(1, 32'h100, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 1, 14'h40, 0, 4'hF, 32'h13, 0, "post_rst");
    idle();
    idle();
    idle();

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
